// File: rtl/spr_register_file_pkg.sv
// Shared SPR numbering, XER reserved-bit mask and the per-register entry type
// for the special-purpose register file.
package ppc_types;

  localparam int unsigned SPR_ADDR_W = 10;
  localparam int unsigned RS_ID_W    = 5;

  localparam logic [SPR_ADDR_W-1:0] SPR_XER = 10'd1;
  localparam logic [SPR_ADDR_W-1:0] SPR_LR  = 10'd8;
  localparam logic [SPR_ADDR_W-1:0] SPR_CTR = 10'd9;

  // XER keeps SO/OV/CA (bits 0:2, big-endian) and the byte count (25:31)
  localparam logic [31:0] XER_WRITE_MASK = 32'hE000_007F;
  localparam logic [31:0] FULL_MASK      = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]        value;
    logic               busy;
    logic [RS_ID_W-1:0] rs_id;
  } spr_entry_t;

  function automatic logic [31:0] mask_value(input logic [31:0] v, input logic [31:0] m);
    return v & m;
  endfunction

endpackage

// File: rtl/spr_register_file_entry.sv
// One architectural SPR: stored value plus busy/tag scoreboard with
// flush > allocate > matching-write priority on the busy state.
module spr_entry
  import ppc_types::*;
#(
  parameter int unsigned RS_ID_WIDTH = RS_ID_W,
  parameter logic [31:0] MASK        = FULL_MASK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [RS_ID_WIDTH-1:0] wr_rs_id,
  input  logic [31:0]            wr_data,
  input  logic                   alloc_en,
  input  logic [RS_ID_WIDTH-1:0] alloc_rs_id,
  input  logic                   flush,
  output logic [31:0]            value,
  output logic                   busy,
  output logic [RS_ID_WIDTH-1:0] rs_id,
  output logic                   wr_match
);

  logic [31:0]            value_r;
  logic                   busy_r;
  logic [RS_ID_WIDTH-1:0] rs_id_r;
  logic                   wr_match_s;

  // A write only retires the producer it was waiting for
  always_comb begin
    wr_match_s = busy_r && (rs_id_r == wr_rs_id);
  end

  // Value register: every accepted write lands, even from a stale producer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= 32'd0;
    end else if (wr_en) begin
      value_r <= mask_value(wr_data, MASK);
    end
  end

  // Busy/tag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= 1'b0;
      rs_id_r <= '0;
    end else if (flush) begin
      busy_r  <= 1'b0;
    end else if (alloc_en) begin
      busy_r  <= 1'b1;
      rs_id_r <= alloc_rs_id;
    end else if (wr_en && wr_match_s) begin
      busy_r  <= 1'b0;
    end
  end

  assign value    = value_r;
  assign busy     = busy_r;
  assign rs_id    = rs_id_r;
  assign wr_match = wr_match_s;

endmodule

// File: rtl/spr_register_file.sv
// XER/LR/CTR register file fed by the system unit's mtspr result bus; the
// dispatcher reads value/busy/tag combinationally and allocates producers.
module spr_register_file
  import ppc_types::*;
#(
  parameter int unsigned RS_ID_WIDTH = RS_ID_W,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spr_input_valid,
  output logic                   spr_input_ready,
  input  logic [RS_ID_WIDTH-1:0] spr_rs_id_in,
  input  logic [SPR_ADDR_W-1:0]  spr_reg_addr_in,
  input  logic [31:0]            spr_result_in,
  input  logic                   alloc_valid,
  input  logic [SPR_ADDR_W-1:0]  alloc_addr,
  input  logic [RS_ID_WIDTH-1:0] alloc_rs_id,
  input  logic                   flush,
  input  logic [SPR_ADDR_W-1:0]  read_addr,
  output logic [31:0]            read_value,
  output logic                   read_busy,
  output logic [RS_ID_WIDTH-1:0] read_rs_id,
  output logic                   read_addr_valid
);

  logic ready_r;
  logic wr_accept_s;

  logic wr_xer_s, wr_lr_s, wr_ctr_s;
  logic al_xer_s, al_lr_s, al_ctr_s;

  logic [31:0]            xer_value_s, lr_value_s, ctr_value_s;
  logic                   xer_busy_s, lr_busy_s, ctr_busy_s;
  logic [RS_ID_WIDTH-1:0] xer_rs_id_s, lr_rs_id_s, ctr_rs_id_s;
  logic                   xer_match_s, lr_match_s, ctr_match_s;

  logic [31:0]            sel_value_s;
  logic                   sel_busy_s;
  logic [RS_ID_WIDTH-1:0] sel_rs_id_s;
  logic                   sel_match_s;
  logic [31:0]            sel_mask_s;
  logic                   sel_valid_s;
  logic                   bypass_s;

  // Ready is low only while in reset; the file never back-pressures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

  assign spr_input_ready = ready_r;

  // Write/allocate address decode; unimplemented numbers hit no entry
  always_comb begin
    wr_accept_s = spr_input_valid && ready_r;
    wr_xer_s    = wr_accept_s && (spr_reg_addr_in == SPR_XER);
    wr_lr_s     = wr_accept_s && (spr_reg_addr_in == SPR_LR);
    wr_ctr_s    = wr_accept_s && (spr_reg_addr_in == SPR_CTR);
    al_xer_s    = alloc_valid && (alloc_addr == SPR_XER);
    al_lr_s     = alloc_valid && (alloc_addr == SPR_LR);
    al_ctr_s    = alloc_valid && (alloc_addr == SPR_CTR);
  end

  spr_entry #(.RS_ID_WIDTH(RS_ID_WIDTH), .MASK(XER_WRITE_MASK)) u_xer (
    .clk(clk), .rst(rst), .wr_en(wr_xer_s), .wr_rs_id(spr_rs_id_in),
    .wr_data(spr_result_in), .alloc_en(al_xer_s), .alloc_rs_id(alloc_rs_id),
    .flush(flush), .value(xer_value_s), .busy(xer_busy_s), .rs_id(xer_rs_id_s),
    .wr_match(xer_match_s)
  );

  spr_entry #(.RS_ID_WIDTH(RS_ID_WIDTH), .MASK(FULL_MASK)) u_lr (
    .clk(clk), .rst(rst), .wr_en(wr_lr_s), .wr_rs_id(spr_rs_id_in),
    .wr_data(spr_result_in), .alloc_en(al_lr_s), .alloc_rs_id(alloc_rs_id),
    .flush(flush), .value(lr_value_s), .busy(lr_busy_s), .rs_id(lr_rs_id_s),
    .wr_match(lr_match_s)
  );

  spr_entry #(.RS_ID_WIDTH(RS_ID_WIDTH), .MASK(FULL_MASK)) u_ctr (
    .clk(clk), .rst(rst), .wr_en(wr_ctr_s), .wr_rs_id(spr_rs_id_in),
    .wr_data(spr_result_in), .alloc_en(al_ctr_s), .alloc_rs_id(alloc_rs_id),
    .flush(flush), .value(ctr_value_s), .busy(ctr_busy_s), .rs_id(ctr_rs_id_s),
    .wr_match(ctr_match_s)
  );

  // Read-side select of the addressed entry
  always_comb begin
    sel_value_s = 32'd0;
    sel_busy_s  = 1'b0;
    sel_rs_id_s = '0;
    sel_match_s = 1'b0;
    sel_mask_s  = FULL_MASK;
    sel_valid_s = 1'b0;
    case (read_addr)
      SPR_XER: begin
        sel_value_s = xer_value_s;
        sel_busy_s  = xer_busy_s;
        sel_rs_id_s = xer_rs_id_s;
        sel_match_s = xer_match_s;
        sel_mask_s  = XER_WRITE_MASK;
        sel_valid_s = 1'b1;
      end
      SPR_LR: begin
        sel_value_s = lr_value_s;
        sel_busy_s  = lr_busy_s;
        sel_rs_id_s = lr_rs_id_s;
        sel_match_s = lr_match_s;
        sel_valid_s = 1'b1;
      end
      SPR_CTR: begin
        sel_value_s = ctr_value_s;
        sel_busy_s  = ctr_busy_s;
        sel_rs_id_s = ctr_rs_id_s;
        sel_match_s = ctr_match_s;
        sel_valid_s = 1'b1;
      end
      default: begin
        sel_valid_s = 1'b0;
      end
    endcase
  end

  // Forward the retiring producer's result so the dispatcher sees it this cycle
  always_comb begin
    bypass_s = (BYPASS != 0) && wr_accept_s && sel_match_s &&
               (spr_reg_addr_in == read_addr);
    if (bypass_s) begin
      read_value = mask_value(spr_result_in, sel_mask_s);
      read_busy  = 1'b0;
    end else begin
      read_value = sel_value_s;
      read_busy  = sel_busy_s;
    end
    read_rs_id      = sel_rs_id_s;
    read_addr_valid = sel_valid_s;
  end

endmodule
